// File: rtl/frame_header_parser_if.sv
// Frame buffer access bundle between the buffer and the header parser.
// master: frame buffer side, slave: parser side.
interface frame_header_parser_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9
);
  logic [DATA_W-1:0] in_frame_data;
  logic              in_frame_valid;
  logic              in_frame_data_valid;
  logic [ADDR_W-1:0] in_frame_tail;
  logic              in_frame_next;
  logic [ADDR_W-1:0] in_frame_addr;
  logic              in_frame_latch_tail;

  modport master (
    output in_frame_data,
    output in_frame_valid,
    output in_frame_data_valid,
    output in_frame_tail,
    output in_frame_next,
    input  in_frame_addr,
    input  in_frame_latch_tail
  );

  modport slave (
    input  in_frame_data,
    input  in_frame_valid,
    input  in_frame_data_valid,
    input  in_frame_tail,
    input  in_frame_next,
    output in_frame_addr,
    output in_frame_latch_tail
  );
endinterface

// File: rtl/frame_header_parser.sv
// Frame header parser: walks the circular buffer from the tail, latches
// EID/length, skips extra header bytes and checks payload length.
module frame_header_parser #(
  parameter int         ADDR_W    = 9,
  parameter int         DATA_W    = 9,
  parameter int         EXTRA_HDR = 0,
  parameter logic [7:0] FRAG_CODE = 8'hFF,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  frame_header_parser_if.slave fb,
  input  logic             eid_filter_en,
  input  logic [7:0]       eid_filter_val,
  input  logic [7:0]       eid_filter_mask,
  output logic [7:0]       header_eid,
  output logic [7:0]       header_len,
  output logic             header_done,
  output logic             header_match,
  output logic             packet_is_empty,
  output logic             is_fragment,
  output logic [CNT_W-1:0] payload_count,
  output logic             length_error,
  output logic             header_abort,
  input  logic             header_done_clear
);

  typedef enum logic [2:0] {
    S_IDLE, S_EID, S_LEN, S_SKIP, S_PAYLOAD, S_WAIT_END
  } state_t;

  localparam logic [3:0] SKIP_LAST =
    4'(EXTRA_HDR > 0 ? EXTRA_HDR - 1 : 0);

  state_t            state, state_n;
  logic [ADDR_W-1:0] offset, offset_n;
  logic [3:0]        skip_cnt, skip_n;
  logic [7:0]        eid_n, len_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              done_n, match_n;
  logic              empty_n, frag_n;
  logic              lerr_n, abort_n;
  logic              latch_q, latch_n;
  logic              set_done, go_idle, inc;
  logic [7:0]        byte_in;

  assign byte_in = fb.in_frame_data[7:0];
  assign fb.in_frame_addr = fb.in_frame_tail + offset;
  assign fb.in_frame_latch_tail = latch_q;

  if (DATA_W > 8) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^fb.in_frame_data[DATA_W-1:8];
  end

  always_comb begin
    state_n  = state;
    skip_n   = skip_cnt;
    eid_n    = header_eid;
    len_n    = header_len;
    frag_n   = is_fragment;
    empty_n  = packet_is_empty;
    cnt_n    = payload_count;
    match_n  = header_match;
    lerr_n   = 1'b0;
    abort_n  = 1'b0;
    latch_n  = 1'b0;
    set_done = 1'b0;
    go_idle  = 1'b0;
    inc      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (fb.in_frame_valid) begin
          inc     = 1'b1;
          state_n = S_EID;
        end
      end
      S_EID: begin
        if (!fb.in_frame_valid) begin
          go_idle = 1'b1;
          abort_n = 1'b1;
        end else if (fb.in_frame_data_valid) begin
          eid_n   = byte_in;
          inc     = 1'b1;
          state_n = S_LEN;
        end
      end
      S_LEN: begin
        if (!fb.in_frame_valid) begin
          go_idle = 1'b1;
          abort_n = 1'b1;
        end else if (fb.in_frame_data_valid) begin
          len_n   = byte_in;
          frag_n  = (byte_in == FRAG_CODE);
          empty_n = (byte_in == 8'h00);
          inc     = 1'b1;
          skip_n  = '0;
          if (EXTRA_HDR > 0) begin
            state_n = S_SKIP;
          end else begin
            set_done = 1'b1;
            state_n  = S_PAYLOAD;
          end
        end
      end
      S_SKIP: begin
        if (!fb.in_frame_valid) begin
          go_idle = 1'b1;
          abort_n = 1'b1;
        end else if (fb.in_frame_data_valid) begin
          inc    = 1'b1;
          skip_n = skip_cnt + 4'd1;
          if (skip_cnt == SKIP_LAST) begin
            set_done = 1'b1;
            state_n  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (!fb.in_frame_valid) begin
          go_idle = 1'b1;
          lerr_n  = !is_fragment && !packet_is_empty &&
                    (32'(payload_count) != 32'(header_len));
        end else if (fb.in_frame_next) begin
          inc = 1'b1;
          if (payload_count != '1)
            cnt_n = payload_count + 1'b1;
        end
      end
      S_WAIT_END: begin
        if (!fb.in_frame_valid)
          go_idle = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Every way back to IDLE releases the frame slot in the buffer.
    if (go_idle) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      latch_n = 1'b1;
    end

    offset_n = (state == S_IDLE || go_idle) ? '0 : offset;
    if (inc)
      offset_n = offset_n + 1'b1;

    done_n = header_done;
    if (set_done) begin
      done_n  = 1'b1;
      match_n = !eid_filter_en ||
        (((header_eid ^ eid_filter_val) & eid_filter_mask) == 8'h00);
    end
    if (header_done_clear || !fb.in_frame_valid)
      done_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      offset          <= '0;
      skip_cnt        <= '0;
      header_eid      <= '0;
      header_len      <= '0;
      header_done     <= 1'b0;
      header_match    <= 1'b0;
      packet_is_empty <= 1'b0;
      is_fragment     <= 1'b0;
      payload_count   <= '0;
      length_error    <= 1'b0;
      header_abort    <= 1'b0;
      latch_q         <= 1'b0;
    end else begin
      state           <= state_n;
      offset          <= offset_n;
      skip_cnt        <= skip_n;
      header_eid      <= eid_n;
      header_len      <= len_n;
      header_done     <= done_n;
      header_match    <= match_n;
      packet_is_empty <= empty_n;
      is_fragment     <= frag_n;
      payload_count   <= cnt_n;
      length_error    <= lerr_n;
      header_abort    <= abort_n;
      latch_q         <= latch_n;
    end
  end

endmodule

// File: tb/tb_frame_header_parser.sv
// Randomized self-checking bench for frame_header_parser against a
// frame-level reference model.
module tb_frame_header_parser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       fen;
  logic [7:0] fval, fmask;
  logic       clr0, clr1;

  logic [7:0] eid0, len0, cnt0;
  logic       done0, match0, empty0, frag0, lerr0, abort0;
  logic [7:0] eid1, len1, cnt1;
  logic       done1, match1, empty1, frag1, lerr1, abort1;

  int checks   = 0;
  int failures = 0;

  frame_header_parser_if #(.ADDR_W(9), .DATA_W(9)) fb0 ();
  frame_header_parser_if #(.ADDR_W(9), .DATA_W(9)) fb1 ();

  frame_header_parser #(.EXTRA_HDR(0)) dut (
    .clk               (clk),
    .rst               (rst),
    .fb                (fb0),
    .eid_filter_en     (fen),
    .eid_filter_val    (fval),
    .eid_filter_mask   (fmask),
    .header_eid        (eid0),
    .header_len        (len0),
    .header_done       (done0),
    .header_match      (match0),
    .packet_is_empty   (empty0),
    .is_fragment       (frag0),
    .payload_count     (cnt0),
    .length_error      (lerr0),
    .header_abort      (abort0),
    .header_done_clear (clr0)
  );

  frame_header_parser #(.EXTRA_HDR(2)) dut_skip (
    .clk               (clk),
    .rst               (rst),
    .fb                (fb1),
    .eid_filter_en     (fen),
    .eid_filter_val    (fval),
    .eid_filter_mask   (fmask),
    .header_eid        (eid1),
    .header_len        (len1),
    .header_done       (done1),
    .header_match      (match1),
    .packet_is_empty   (empty1),
    .is_fragment       (frag1),
    .payload_count     (cnt1),
    .length_error      (lerr1),
    .header_abort      (abort1),
    .header_done_clear (clr1)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame on the EXTRA_HDR=0 instance; expectations from the
  // frame's fields alone.
  task automatic run_frame(input logic [8:0] tail,
                           input logic [7:0] eid,
                           input logic [7:0] len,
                           input int nexts,
                           input int clr_mode);
    logic [8:0] a;
    logic m, fr, em, er;
    int c;
    m  = !fen || (((eid ^ fval) & fmask) == 8'h00);
    fr = (len == 8'hFF);
    em = (len == 8'h00);
    c  = (nexts > 255) ? 255 : nexts;
    er = !fr && !em && (c != int'(len));

    @(negedge clk);
    fb0.in_frame_tail  = tail;
    fb0.in_frame_valid = 1'b1;
    @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    a = tail + 9'd1;
    check("addr_eid", fb0.in_frame_addr, a);
    fb0.in_frame_data = {1'($urandom_range(0, 1)), eid};
    fb0.in_frame_data_valid = 1'b1;
    @(negedge clk);
    fb0.in_frame_data_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    a = tail + 9'd2;
    check("addr_len", fb0.in_frame_addr, a);
    check("header_eid", eid0, eid);
    check("done_early", done0, 1'b0);
    fb0.in_frame_data = {1'($urandom_range(0, 1)), len};
    fb0.in_frame_data_valid = 1'b1;
    clr0 = (clr_mode == 2);
    @(negedge clk);
    fb0.in_frame_data_valid = 1'b0;
    clr0 = 1'b0;
    check("header_done", done0, clr_mode != 2);
    if (clr_mode != 2)
      check("header_match", match0, m);
    check("header_len", len0, len);
    check("is_fragment", frag0, fr);
    check("packet_empty", empty0, em);
    a = tail + 9'd3;
    check("addr_pay0", fb0.in_frame_addr, a);

    for (int i = 0; i < nexts; i++) begin
      fb0.in_frame_next = 1'b1;
      fb0.in_frame_data_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      fb0.in_frame_next = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    fb0.in_frame_data_valid = 1'b0;
    check("payload_count", cnt0, c);
    a = tail + 9'(3 + nexts);
    check("addr_payN", fb0.in_frame_addr, a);

    if (clr_mode == 1) begin
      clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      check("done_cleared", done0, 1'b0);
      @(negedge clk);
      check("done_stays0", done0, 1'b0);
    end

    fb0.in_frame_valid = 1'b0;
    @(negedge clk);
    check("latch_tail", fb0.in_frame_latch_tail, 1'b1);
    check("length_error", lerr0, er);
    check("no_abort", abort0, 1'b0);
    check("done_release", done0, 1'b0);
    @(negedge clk);
    check("latch_pulse", fb0.in_frame_latch_tail, 1'b0);
    check("lerr_pulse", lerr0, 1'b0);
    check("count_clr", cnt0, 0);
    check("addr_idle", fb0.in_frame_addr, tail);
  endtask

  initial begin
    logic [8:0] t;
    logic [7:0] e, l;
    int n;

    fen = 0; fval = 0; fmask = 0; clr0 = 0; clr1 = 0;
    fb0.in_frame_data = '0; fb0.in_frame_valid = 0;
    fb0.in_frame_data_valid = 0; fb0.in_frame_next = 0;
    fb0.in_frame_tail = 9'h055;
    fb1.in_frame_data = '0; fb1.in_frame_valid = 0;
    fb1.in_frame_data_valid = 0; fb1.in_frame_next = 0;
    fb1.in_frame_tail = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs",
      {eid0, len0, done0, match0, empty0, frag0,
       cnt0, lerr0, abort0, fb0.in_frame_latch_tail}, 0);
    check("reset_addr", fb0.in_frame_addr, 9'h055);
    rst = 1'b0;

    run_frame(9'h1F0, 8'h42, 8'h03, 3, 0);
    run_frame(9'h1FE, 8'h17, 8'h02, 2, 0);
    run_frame(9'h010, 8'h20, 8'hFF, 5, 0);
    run_frame(9'h011, 8'h21, 8'h00, 0, 0);
    run_frame(9'h012, 8'h22, 8'h00, 3, 0);
    run_frame(9'h020, 8'h33, 8'h04, 2, 0);
    run_frame(9'h030, 8'h34, 8'h10, 260, 0);
    run_frame(9'h040, 8'h35, 8'h02, 2, 1);
    run_frame(9'h050, 8'h36, 8'h02, 2, 2);

    fen = 1; fval = 8'h40; fmask = 8'hF0;
    run_frame(9'h060, 8'h4A, 8'h01, 1, 0);
    run_frame(9'h070, 8'h5A, 8'h01, 1, 0);

    for (int k = 0; k < 25; k++) begin
      int r;
      fen   = 1'($urandom_range(0, 1));
      fval  = 8'($urandom);
      fmask = 8'($urandom);
      t = 9'($urandom_range(0, 511));
      e = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      l = 8'h00;
      else if (r == 1) l = 8'hFF;
      else             l = 8'($urandom_range(1, 8));
      if (l != 8'hFF && $urandom_range(0, 1) == 1) n = int'(l);
      else n = $urandom_range(0, 9);
      run_frame(t, e, l, n, $urandom_range(0, 2));
    end

    // Abort while waiting for the EID word.
    @(negedge clk);
    fb0.in_frame_tail = 9'h100;
    fb0.in_frame_valid = 1'b1;
    @(negedge clk);
    fb0.in_frame_valid = 1'b0;
    @(negedge clk);
    check("abort_eid", abort0, 1'b1);
    check("abort_latch", fb0.in_frame_latch_tail, 1'b1);
    check("abort_done", done0, 1'b0);
    @(negedge clk);
    check("abort_pulse", abort0, 1'b0);

    // Reset in the middle of the payload.
    fen = 0;
    fb0.in_frame_tail = 9'h0A0;
    fb0.in_frame_valid = 1'b1;
    @(negedge clk);
    fb0.in_frame_data = 9'h0AB;
    fb0.in_frame_data_valid = 1'b1;
    @(negedge clk);
    fb0.in_frame_data = 9'h005;
    @(negedge clk);
    fb0.in_frame_data_valid = 1'b0;
    fb0.in_frame_next = 1'b1;
    repeat (2) @(negedge clk);
    fb0.in_frame_next = 1'b0;
    check("pre_rst_cnt", cnt0, 2);
    rst = 1'b1;
    fb0.in_frame_valid = 1'b0;
    @(negedge clk);
    check("midrst_outs",
      {eid0, len0, done0, match0, empty0, frag0,
       cnt0, lerr0, abort0, fb0.in_frame_latch_tail}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_notail", fb0.in_frame_latch_tail, 1'b0);
    check("midrst_addr", fb0.in_frame_addr, 9'h0A0);

    // Two extra header bytes: normal frame.
    fb1.in_frame_tail = 9'h1FC;
    fb1.in_frame_valid = 1'b1;
    @(negedge clk);
    fb1.in_frame_data = 9'h011;
    fb1.in_frame_data_valid = 1'b1;
    @(negedge clk);
    fb1.in_frame_data = 9'h002;
    @(negedge clk);
    check("skip_addr0", fb1.in_frame_addr, 9'h1FF);
    check("skip_done0", done1, 1'b0);
    fb1.in_frame_data = 9'h1EE;
    @(negedge clk);
    check("skip_addr1", fb1.in_frame_addr, 9'h000);
    check("skip_done1", done1, 1'b0);
    @(negedge clk);
    fb1.in_frame_data_valid = 1'b0;
    check("skip_done", done1, 1'b1);
    check("skip_eid", eid1, 8'h11);
    check("skip_len", len1, 8'h02);
    check("skip_pay_addr", fb1.in_frame_addr, 9'h001);
    fb1.in_frame_next = 1'b1;
    repeat (2) @(negedge clk);
    fb1.in_frame_next = 1'b0;
    fb1.in_frame_valid = 1'b0;
    @(negedge clk);
    check("skip_latch", fb1.in_frame_latch_tail, 1'b1);
    check("skip_lerr", lerr1, 1'b0);
    @(negedge clk);

    // Two extra header bytes: frame drops during the skip.
    fb1.in_frame_tail = 9'h080;
    fb1.in_frame_valid = 1'b1;
    @(negedge clk);
    fb1.in_frame_data = 9'h033;
    fb1.in_frame_data_valid = 1'b1;
    @(negedge clk);
    fb1.in_frame_data = 9'h004;
    @(negedge clk);
    fb1.in_frame_data = 9'h000;
    @(negedge clk);
    fb1.in_frame_data_valid = 1'b0;
    fb1.in_frame_valid = 1'b0;
    check("skipab_done0", done1, 1'b0);
    @(negedge clk);
    check("skipab_abort", abort1, 1'b1);
    check("skipab_latch", fb1.in_frame_latch_tail, 1'b1);
    check("skipab_done", done1, 1'b0);
    @(negedge clk);
    check("skipab_pulse", abort1, 1'b0);
    check("skipab_done2", done1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
